// File: rtl/decode_packet.sv
// rtl/decode_packet.sv - reassembles a DFX word from Aurora RX packets
//
// Purpose: pops PKT_COUNT packets from the Aurora RX FIFO, checks that their
// sequence numbers run 0..PKT_COUNT-1 and that all come from the same source
// router, and presents the rebuilt word to the decode controller.
// Packet layout (LSB first): [1:0] src_router, [6:2] pkt_number, [8:7] TTL,
// [AURORA_DATA_WIDTH-1:9] payload.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pkt_valid       RX FIFO has a packet
//   pkt_data        packet at the head of the RX FIFO
//   pkt_ready       packet accepted this cycle (FIFO read enable = valid & ready)
//   dfx_valid       reassembled word available
//   dfx_ready       decode controller takes the word
//   data_dfx_recv   reassembled word
//   src_router_out  source router of the frame
//   ttl_out         TTL of packet 0 of the frame
//   decode_err      one-cycle pulse per offending packet
//   frame_cnt       frames delivered, wraps
module decode_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 256,
  parameter int PAYLOAD_WIDTH     = AURORA_DATA_WIDTH - 9,
  parameter int PKT_COUNT         = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pkt_valid,
  input  logic [AURORA_DATA_WIDTH-1:0] pkt_data,
  output logic                         pkt_ready,
  output logic                         dfx_valid,
  input  logic                         dfx_ready,
  output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
  output logic [1:0]                   src_router_out,
  output logic [1:0]                   ttl_out,
  output logic                         decode_err,
  output logic [15:0]                  frame_cnt
);

  // The last packet only carries what is left of the word.
  localparam int LAST_W = DATA_DFX_WIDTH - (PKT_COUNT - 1) * PAYLOAD_WIDTH;
  localparam logic [4:0] LAST_NUM = 5'(PKT_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [4:0]                  exp_q, exp_d;
  logic [DATA_DFX_WIDTH-1:0]   data_d;
  logic [1:0]                  src_d, ttl_d;
  logic                        err_d;
  logic [15:0]                 cnt_d;

  logic                        accept;
  logic [4:0]                  pkt_num;
  logic [1:0]                  pkt_src;
  logic [1:0]                  pkt_ttl;
  logic [PAYLOAD_WIDTH-1:0]    pkt_payload;

  assign pkt_num     = pkt_data[6:2];
  assign pkt_src     = pkt_data[1:0];
  assign pkt_ttl     = pkt_data[8:7];
  assign pkt_payload = pkt_data[AURORA_DATA_WIDTH-1:9];

  assign pkt_ready = ~rst & (state_q != OUTPUT);
  assign accept    = pkt_valid & pkt_ready;
  assign dfx_valid = (state_q == OUTPUT);

  // Drops payload into slice idx of base; the last slice keeps only the
  // low LAST_W payload bits.
  function automatic logic [DATA_DFX_WIDTH-1:0] put_slice(
    input logic [DATA_DFX_WIDTH-1:0] base,
    input logic [4:0]                idx,
    input logic [PAYLOAD_WIDTH-1:0]  pay
  );
    logic [DATA_DFX_WIDTH-1:0] w;
    w = base;
    for (int k = 0; k < PKT_COUNT - 1; k++) begin
      if (idx == 5'(k)) begin
        w[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = pay;
      end
    end
    if (idx == LAST_NUM) begin
      w[(PKT_COUNT-1)*PAYLOAD_WIDTH +: LAST_W] = pay[LAST_W-1:0];
    end
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    data_d  = data_dfx_recv;
    src_d   = src_router_out;
    ttl_d   = ttl_out;
    err_d   = 1'b0;
    cnt_d   = frame_cnt;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (pkt_num == 5'd0) begin
            data_d  = put_slice('0, 5'd0, pkt_payload);
            src_d   = pkt_src;
            ttl_d   = pkt_ttl;
            exp_d   = 5'd1;
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (accept) begin
          if (pkt_num == exp_q && pkt_src == src_router_out) begin
            data_d = put_slice(data_dfx_recv, pkt_num, pkt_payload);
            if (exp_q == LAST_NUM) begin
              exp_d   = 5'd0;
              state_d = OUTPUT;
            end else begin
              exp_d = exp_q + 5'd1;
            end
          end else if (pkt_num == 5'd0) begin
            // A fresh packet 0 mid-frame abandons the old frame but is
            // itself a valid start, so it is kept as slice 0.
            err_d   = 1'b1;
            data_d  = put_slice('0, 5'd0, pkt_payload);
            src_d   = pkt_src;
            ttl_d   = pkt_ttl;
            exp_d   = 5'd1;
            state_d = COLLECT;
          end else begin
            err_d   = 1'b1;
            data_d  = '0;
            exp_d   = 5'd0;
            state_d = IDLE;
          end
        end
      end

      OUTPUT: begin
        if (dfx_ready) begin
          cnt_d   = frame_cnt + 16'd1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      exp_q          <= 5'd0;
      data_dfx_recv  <= '0;
      src_router_out <= 2'd0;
      ttl_out        <= 2'd0;
      decode_err     <= 1'b0;
      frame_cnt      <= 16'd0;
    end else begin
      state_q        <= state_d;
      exp_q          <= exp_d;
      data_dfx_recv  <= data_d;
      src_router_out <= src_d;
      ttl_out        <= ttl_d;
      decode_err     <= err_d;
      frame_cnt      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_packet.sv
// tb/tb_decode_packet.sv - bench for decode_packet against a queue-based frame model
module tb_decode_packet;

  localparam int AW = 256;
  localparam int PW = AW - 9;
  localparam int PC = 5;
  localparam int DW = 1034;

  logic          clk = 1'b0;
  logic          rst;
  logic          pkt_valid;
  logic [AW-1:0] pkt_data;
  logic          pkt_ready;
  logic          dfx_valid;
  logic          dfx_ready;
  logic [DW-1:0] data_dfx_recv;
  logic [1:0]    src_router_out;
  logic [1:0]    ttl_out;
  logic          decode_err;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  // Model: packets of the frame being collected, in arrival order.
  logic [AW-1:0] frame_q[$];
  logic [DW-1:0] m_word;
  logic [1:0]    m_src;
  logic [1:0]    m_ttl;
  logic [15:0]   m_cnt;
  logic          m_err;

  decode_packet dut (
    .clk            (clk),
    .rst            (rst),
    .pkt_valid      (pkt_valid),
    .pkt_data       (pkt_data),
    .pkt_ready      (pkt_ready),
    .dfx_valid      (dfx_valid),
    .dfx_ready      (dfx_ready),
    .data_dfx_recv  (data_dfx_recv),
    .src_router_out (src_router_out),
    .ttl_out        (ttl_out),
    .decode_err     (decode_err),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk(input int num, input logic [1:0] src,
                                       input logic [1:0] ttl, input logic [DW-1:0] w);
    logic [PC*PW-1:0] big;
    logic [PW-1:0]    pay;
    big = '0;
    big[DW-1:0] = w;
    pay = big[num*PW +: PW];
    return {pay, ttl, 5'(num), src};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  function automatic logic [AW-1:0] rand_pkt();
    logic [AW-1:0] p;
    for (int i = 0; i < AW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // One clock: drive at the negedge, step the model at the posedge, check at
  // the following negedge.
  task automatic step(input logic v, input logic [AW-1:0] d, input logic rdy, input logic r);
    logic           full;
    logic           acc;
    int             num;
    logic [1:0]     src;
    logic [PC*PW-1:0] big;
    rst       = r;
    pkt_valid = v;
    pkt_data  = d;
    dfx_ready = rdy;
    full = (frame_q.size() == PC);
    #1;
    chk("pkt_ready", 64'(pkt_ready), 64'(!r && !full));
    acc = v && !r && !full;
    @(posedge clk);
    m_err = 1'b0;
    num   = int'(d[6:2]);
    src   = d[1:0];
    if (r) begin
      frame_q.delete();
      m_cnt = 16'd0; m_word = '0; m_src = 2'd0; m_ttl = 2'd0;
    end else if (full) begin
      if (rdy) begin
        frame_q.delete();
        m_cnt = m_cnt + 16'd1;
      end
    end else if (acc) begin
      if (frame_q.size() == 0) begin
        if (num == 0) frame_q.push_back(d);
        else m_err = 1'b1;
      end else if (num == frame_q.size() && src == frame_q[0][1:0]) begin
        frame_q.push_back(d);
      end else if (num == 0) begin
        m_err = 1'b1;
        frame_q.delete();
        frame_q.push_back(d);
      end else begin
        m_err = 1'b1;
        frame_q.delete();
      end
      if (frame_q.size() == PC) begin
        big = '0;
        foreach (frame_q[i]) big[i*PW +: PW] = frame_q[i][AW-1:9];
        m_word = big[DW-1:0];
        m_src  = frame_q[0][1:0];
        m_ttl  = frame_q[0][8:7];
      end
    end
    @(negedge clk);
    chk("dfx_valid", 64'(dfx_valid), 64'(frame_q.size() == PC));
    chk("decode_err", 64'(decode_err), 64'(m_err));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    if (frame_q.size() == PC || r) begin
      checks++;
      assert (data_dfx_recv === m_word) else begin
        errors++;
        $error("FAIL data_dfx_recv observed_lo=%0h expected_lo=%0h", data_dfx_recv[63:0], m_word[63:0]);
      end
      chk("src_router_out", 64'(src_router_out), 64'(m_src));
      chk("ttl_out", 64'(ttl_out), 64'(m_ttl));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input logic [1:0] src,
                            input logic [1:0] ttl, input logic rdy);
    for (int n = 0; n < PC; n++) step(1'b1, mk(n, src, ttl, w), rdy, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;
    logic [AW-1:0] p;
    int            num;

    rst = 1'b1; pkt_valid = 1'b0; pkt_data = '0; dfx_ready = 1'b0;
    m_cnt = 16'd0; m_word = '0; m_src = 2'd0; m_ttl = 2'd0; m_err = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Nominal frame: word 0x3FF...A5, src 1, TTL 2
    w0 = '1;
    w0[7:0] = 8'hA5;
    send_frame(w0, 2'b01, 2'b10, 1'b1);
    chk("nominal_valid", 64'(dfx_valid), 64'd1);
    chk("nominal_src", 64'(src_router_out), 64'd1);
    chk("nominal_ttl", 64'(ttl_out), 64'd2);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("nominal_cnt", 64'(frame_cnt), 64'd1);
    chk("nominal_ready_after", 64'(pkt_ready), 64'd1);

    // Backpressure: 10 cycles held with the next packet 0 waiting
    w1 = rand_word();
    w2 = rand_word();
    send_frame(w1, 2'b10, 2'b01, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, mk(0, 2'b11, 2'b00, w2), 1'b0, 1'b0);
    step(1'b1, mk(0, 2'b11, 2'b00, w2), 1'b1, 1'b0);
    chk("bp_handshake_cnt", 64'(frame_cnt), 64'd2);
    send_frame(w2, 2'b11, 2'b00, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Gapped input
    for (int n = 0; n < PC; n++) begin
      step(1'b1, mk(n, 2'b01, 2'b10, w0), 1'b1, 1'b0);
      if (n < PC - 1) step(1'b0, rand_pkt(), 1'b1, 1'b0);
    end
    chk("gapped_valid", 64'(dfx_valid), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Sequence error 0,1,3 then a clean frame
    w1 = rand_word();
    step(1'b1, mk(0, 2'b01, 2'b11, w1), 1'b1, 1'b0);
    step(1'b1, mk(1, 2'b01, 2'b11, w1), 1'b1, 1'b0);
    step(1'b1, mk(3, 2'b01, 2'b11, w1), 1'b1, 1'b0);
    chk("seq_err_pulse", 64'(decode_err), 64'd1);
    send_frame(w1, 2'b01, 2'b11, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Restart: 0,1,0,1,2,3,4
    w2 = rand_word();
    step(1'b1, mk(0, 2'b00, 2'b01, w1), 1'b1, 1'b0);
    step(1'b1, mk(1, 2'b00, 2'b01, w1), 1'b1, 1'b0);
    step(1'b1, mk(0, 2'b10, 2'b00, w2), 1'b1, 1'b0);
    chk("restart_err", 64'(decode_err), 64'd1);
    for (int n = 1; n < PC; n++) step(1'b1, mk(n, 2'b10, 2'b00, w2), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Source mismatch on packet 2
    step(1'b1, mk(0, 2'b01, 2'b00, w2), 1'b1, 1'b0);
    step(1'b1, mk(1, 2'b01, 2'b00, w2), 1'b1, 1'b0);
    step(1'b1, mk(2, 2'b11, 2'b00, w2), 1'b1, 1'b0);
    chk("src_err", 64'(decode_err), 64'd1);
    step(1'b1, mk(3, 2'b01, 2'b00, w2), 1'b1, 1'b0);

    // Reset mid-collect after packet 2, then a clean frame
    for (int n = 0; n < 3; n++) step(1'b1, mk(n, 2'b01, 2'b01, w0), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    send_frame(w1, 2'b01, 2'b01, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_reset_cnt", 64'(frame_cnt), 64'd1);

    // Randomized traffic, mostly well-formed
    for (int i = 0; i < 600; i++) begin
      p = rand_pkt();
      num = (frame_q.size() == PC) ? 0 : frame_q.size();
      if ($urandom_range(0, 7) == 0) num = $urandom_range(0, 31);
      p[6:2] = 5'(num);
      p[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3))
               : ((frame_q.size() > 0) ? frame_q[0][1:0] : 2'($urandom_range(0, 3)));
      step(($urandom_range(0, 3) != 0), p, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 99) == 0));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_packet.md
Name: decode_packet

Overview:
- Receive-side counterpart of the packet encoder. Reassembles a DFX word of DATA_DFX_WIDTH bits from PKT_COUNT consecutive AURORA_DATA_WIDTH-bit packets popped from the Aurora RX FIFO.
- Checks sequence numbers and source consistency, then presents the full word to the decode controller over a valid/ready handshake.
- Packet format, LSB first: [1:0] src_router, [6:2] pkt_number, [8:7] TTL, [AURORA_DATA_WIDTH-1:9] payload.

Parameters:
DATA_WIDTH, 1024, data part of the DFX word
ADDR_WIDTH, 10, address part of the DFX word
DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH, reassembled word width (1034)
AURORA_DATA_WIDTH, 256, packet width
PAYLOAD_WIDTH, AURORA_DATA_WIDTH-9, payload bits per packet (247)
PKT_COUNT, 5, packets per frame; legal range 2..32; (PKT_COUNT-1)*PAYLOAD_WIDTH < DATA_DFX_WIDTH <= PKT_COUNT*PAYLOAD_WIDTH

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
pkt_valid  input  1  RX FIFO has a packet
pkt_data  input  AURORA_DATA_WIDTH  packet from RX FIFO
pkt_ready  output  1  block accepts packet this cycle (FIFO read enable = pkt_valid & pkt_ready)
dfx_valid  output  1  reassembled word available
dfx_ready  input  1  decode controller takes word
data_dfx_recv  output  DATA_DFX_WIDTH  reassembled word
src_router_out  output  2  src_router of the frame
ttl_out  output  2  TTL of packet 0 of the frame
decode_err  output  1  one-cycle pulse per protocol error
frame_cnt  output  16  frames delivered, wraps 0xFFFF->0

Behaviour:
- Single clock, synchronous active-high reset. All state changes occur on the rising edge of clk.
- Reset: state=IDLE; dfx_valid, decode_err, data_dfx_recv, src_router_out, ttl_out, frame_cnt, expected counter all 0. pkt_ready=0 while rst=1. A reset mid-frame or while in OUTPUT discards everything.
- pkt_ready is combinational: 1 in IDLE and COLLECT, 0 in OUTPUT. No other inputs affect it.
- Accept = pkt_valid & pkt_ready. The fields num=pkt_data[6:2], src=pkt_data[1:0] are decoded from the accepted packet.
- Slice k (k<PKT_COUNT-1) writes data_dfx_recv[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] from payload.
- The last slice writes only the remaining DATA_DFX_WIDTH-(PKT_COUNT-1)*PAYLOAD_WIDTH bits (46 at defaults) from payload LSBs. Higher payload bits are ignored.
- FSM IDLE:
  - Accept with num==0: clear data_dfx_recv, write slice 0, latch src_router_out/ttl_out, expected=1, go to COLLECT.
  - Accept with num!=0: drop the packet, pulse decode_err, stay in IDLE.
- FSM COLLECT:
  - Accept with num==expected and src==src_router_out: write slice.
    - If expected==PKT_COUNT-1, go to OUTPUT.
    - Otherwise expected+1.
  - Accept with num==0 (out of order): pulse decode_err, restart the frame exactly as in IDLE with this packet as slice 0.
  - Any other mismatch (wrong num or wrong src): pulse decode_err, clear data_dfx_recv, go to IDLE.
  - No accept: hold.
- FSM OUTPUT:
  - dfx_valid=1. data_dfx_recv, src_router_out and ttl_out are stable.
  - On dfx_ready: dfx_valid=0 next cycle, frame_cnt+1, go to IDLE.
  - dfx_ready may be high in the same cycle dfx_valid rises; the handshake completes in that cycle.
- Latency: last packet accepted in cycle N gives dfx_valid=1 in cycle N+1. With dfx_ready held high, dfx_valid=0 in N+2 and pkt_ready=1 in N+2.
- Throughput: one packet per cycle in COLLECT. Minimum frame period is PKT_COUNT+1 cycles.
- decode_err is registered, high for exactly one cycle per offending packet, and never asserted in OUTPUT.
- TTL is carried through only, never checked.

Test Plan:
- Nominal frame: 5 back-to-back packets num 0..4, src=2'b01, TTL=2'b10, payload slices of word 0x3FF...A5; dfx_ready=1.
  -> dfx_valid=1 one cycle after pkt 4; data_dfx_recv equals the original 1034-bit word; src_router_out=1; ttl_out=2; frame_cnt=1.
- Backpressure: dfx_ready=0 for 10 cycles after a complete frame, next frame's pkt 0 waiting.
  -> pkt_ready=0 and dfx_valid=1 for all 10 cycles; data stable; pkt 0 accepted the cycle after the dfx handshake.
- Gapped input: pkt_valid toggles 1/0 across a frame.
  -> same word as the nominal case; expected counter advances only on accepts.
- Sequence error: num 0,1,3. -> decode_err pulse on num 3; state IDLE; a following 0..4 frame decodes correctly.
- Restart and src mismatch:
  - num 0,1,0,1,2,3,4 -> decode_err at the second 0; the word is built from the last five packets.
  - Separate frame with pkt 2 src=2'b11 vs 2'b01 -> decode_err; back in IDLE.
- Reset mid-COLLECT after pkt 2: rst=1 for 1 cycle. -> all outputs 0; a following clean frame decodes correctly; frame_cnt restarts at 1.
